// File: rtl/alu_share_arbiter_pkg.sv
// alu_share_arbiter_pkg
//   Shared definitions for the shared-ALU arbiter: requester ids, the ALU
//   select width and the ALU select codes used by both requesters.
package alu_share_arbiter_pkg;

  // Requester ids
  localparam logic REQ_ISSUE = 1'b0;  // integer issue stage
  localparam logic REQ_SEQ   = 1'b1;  // address/CSR sequencer

  // ALU select width and codes
  localparam int SEL_W = 4;

  localparam logic [SEL_W-1:0] SEL_ADD  = 4'd0;
  localparam logic [SEL_W-1:0] SEL_SUB  = 4'd1;
  localparam logic [SEL_W-1:0] SEL_AND  = 4'd2;
  localparam logic [SEL_W-1:0] SEL_OR   = 4'd3;
  localparam logic [SEL_W-1:0] SEL_XOR  = 4'd4;
  localparam logic [SEL_W-1:0] SEL_SLL  = 4'd5;
  localparam logic [SEL_W-1:0] SEL_SRL  = 4'd6;
  localparam logic [SEL_W-1:0] SEL_SRA  = 4'd7;
  localparam logic [SEL_W-1:0] SEL_SLT  = 4'd8;
  localparam logic [SEL_W-1:0] SEL_SLTU = 4'd9;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// alu_share_arbiter_alu
//   Purely combinational integer ALU shared by the arbiter.
//   Ports:
//     x, y  in   XLEN   operands (shift amount is the full y value)
//     sel   in   SEL_W  operation select (SEL_* codes)
//     z     out  XLEN   result; undefined select codes give zero
module alu_share_arbiter_alu
  import alu_share_arbiter_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0]  x,
  input  logic [XLEN-1:0]  y,
  input  logic [SEL_W-1:0] sel,
  output logic [XLEN-1:0]  z
);

  // Operation decode
  always_comb begin
    z = {XLEN{1'b0}};
    case (sel)
      SEL_ADD:  z = x + y;
      SEL_SUB:  z = x - y;
      SEL_AND:  z = x & y;
      SEL_OR:   z = x | y;
      SEL_XOR:  z = x ^ y;
      SEL_SLL:  z = x << y;
      SEL_SRL:  z = x >> y;
      SEL_SRA:  z = $unsigned($signed(x) >>> y);
      SEL_SLT:  z = {{(XLEN-1){1'b0}}, ($signed(x) < $signed(y))};
      SEL_SLTU: z = {{(XLEN-1){1'b0}}, (x < y)};
      default:  z = {XLEN{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one combinational ALU between two valid/ready requesters with
//   round-robin arbitration and a single registered result slot. A held
//   result may drain and a new request may be accepted in the same cycle,
//   giving one operation per cycle while the owner keeps rsp_ready high.
//   Ports:
//     clk, rst                  clock, synchronous active-high reset
//     reqN_valid/ready          request handshake for requester N
//     reqN_x, reqN_y, reqN_sel  operands and ALU select
//     rspN_valid/ready          response handshake for requester N
//     rspN_z                    registered result (qualify with rspN_valid)
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [XLEN-1:0]  req0_x,
  input  logic [XLEN-1:0]  req0_y,
  input  logic [SEL_W-1:0] req0_sel,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [XLEN-1:0]  rsp0_z,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [XLEN-1:0]  req1_x,
  input  logic [XLEN-1:0]  req1_y,
  input  logic [SEL_W-1:0] req1_sel,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [XLEN-1:0]  rsp1_z
);

  logic             rsp_full_r;
  logic             owner_r;
  logic [XLEN-1:0]  rsp_z_r;
  logic             rr_last_r;

  logic             drain_s;
  logic             can_accept_s;
  logic             grant_s;
  logic             any_grant_s;
  logic             accept_s;
  logic [XLEN-1:0]  alu_x_s;
  logic [XLEN-1:0]  alu_y_s;
  logic [SEL_W-1:0] alu_sel_s;
  logic [XLEN-1:0]  alu_z_s;

  // The held result leaves when its owner is ready; that frees the slot
  // for a refill in the very same cycle.
  assign drain_s      = rsp_full_r && (owner_r ? rsp1_ready : rsp0_ready);
  assign can_accept_s = !rsp_full_r || drain_s;

  // Round-robin grant; on a contest the requester that did not win last time goes
  always_comb begin
    grant_s     = REQ_ISSUE;
    any_grant_s = 1'b0;
    if (!can_accept_s) begin
      grant_s     = REQ_ISSUE;
      any_grant_s = 1'b0;
    end else if (req0_valid && req1_valid) begin
      grant_s     = ~rr_last_r;
      any_grant_s = 1'b1;
    end else if (req0_valid) begin
      grant_s     = REQ_ISSUE;
      any_grant_s = 1'b1;
    end else if (req1_valid) begin
      grant_s     = REQ_SEQ;
      any_grant_s = 1'b1;
    end else begin
      grant_s     = REQ_ISSUE;
      any_grant_s = 1'b0;
    end
  end

  // Nothing is accepted while reset is asserted
  assign accept_s   = any_grant_s && !rst;
  assign req0_ready = accept_s && (grant_s == REQ_ISSUE);
  assign req1_ready = accept_s && (grant_s == REQ_SEQ);

  // ALU operand mux: port 0 drives the ALU unless port 1 holds the grant
  always_comb begin
    alu_x_s   = req0_x;
    alu_y_s   = req0_y;
    alu_sel_s = req0_sel;
    if (any_grant_s && (grant_s == REQ_SEQ)) begin
      alu_x_s   = req1_x;
      alu_y_s   = req1_y;
      alu_sel_s = req1_sel;
    end else begin
      alu_x_s   = req0_x;
      alu_y_s   = req0_y;
      alu_sel_s = req0_sel;
    end
  end

  alu_share_arbiter_alu #(
    .XLEN (XLEN)
  ) u_alu (
    .x   (alu_x_s),
    .y   (alu_y_s),
    .sel (alu_sel_s),
    .z   (alu_z_s)
  );

  // Result slot, owner and round-robin pointer. rr_last resets to the
  // sequencer so the issue stage wins the first contest after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_full_r <= 1'b0;
      owner_r    <= REQ_ISSUE;
      rsp_z_r    <= {XLEN{1'b0}};
      rr_last_r  <= REQ_SEQ;
    end else if (accept_s) begin
      rsp_full_r <= 1'b1;
      owner_r    <= grant_s;
      rsp_z_r    <= alu_z_s;
      rr_last_r  <= grant_s;
    end else if (drain_s) begin
      rsp_full_r <= 1'b0;
      owner_r    <= owner_r;
      rsp_z_r    <= rsp_z_r;
      rr_last_r  <= rr_last_r;
    end else begin
      rsp_full_r <= rsp_full_r;
      owner_r    <= owner_r;
      rsp_z_r    <= rsp_z_r;
      rr_last_r  <= rr_last_r;
    end
  end

  assign rsp0_valid = rsp_full_r && (owner_r == REQ_ISSUE);
  assign rsp1_valid = rsp_full_r && (owner_r == REQ_SEQ);
  assign rsp0_z     = rsp_z_r;
  assign rsp1_z     = rsp_z_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
//   Directed bench for alu_share_arbiter. Inputs change just after the
//   falling edge and outputs are checked 1 time unit later, well away
//   from the rising edge where state updates.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  localparam int XLEN = 64;

  logic             clk;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [XLEN-1:0]  req0_x, req0_y, req1_x, req1_y;
  logic [SEL_W-1:0] req0_sel, req1_sel;
  logic             rsp0_valid, rsp1_valid;
  logic             rsp0_ready, rsp1_ready;
  logic [XLEN-1:0]  rsp0_z, rsp1_z;

  int errors = 0;
  int checks = 0;

  alu_share_arbiter #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_x     (req0_x),
    .req0_y     (req0_y),
    .req0_sel   (req0_sel),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_z     (rsp0_z),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_x     (req1_x),
    .req1_y     (req1_y),
    .req1_sel   (req1_sel),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_z     (rsp1_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] observed,
                       input logic [XLEN-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next falling edge
  task automatic next_cycle();
    @(negedge clk);
  endtask

  // Small op table exercised back-to-back on port 0
  logic [SEL_W-1:0] tsel [5];
  logic [XLEN-1:0]  tx   [5];
  logic [XLEN-1:0]  ty   [5];
  logic [XLEN-1:0]  tz   [5];

  initial begin
    tsel[0] = SEL_AND; tx[0] = 64'hF0F0; ty[0] = 64'hFF00; tz[0] = 64'hF000;
    tsel[1] = SEL_OR;  tx[1] = 64'hF0F0; ty[1] = 64'h0F0F; tz[1] = 64'hFFFF;
    tsel[2] = SEL_SLL; tx[2] = 64'd1;    ty[2] = 64'd4;    tz[2] = 64'd16;
    tsel[3] = SEL_SRL; tx[3] = 64'h100;  ty[3] = 64'd4;    tz[3] = 64'h10;
    tsel[4] = SEL_SRA; tx[4] = 64'hFFFF_FFFF_FFFF_FFF0; ty[4] = 64'd2;
    tz[4] = 64'hFFFF_FFFF_FFFF_FFFC;

    rst = 1'b1;
    req0_valid = 1'b1; req0_x = 64'd5; req0_y = 64'd7; req0_sel = SEL_ADD;
    req1_valid = 1'b1; req1_x = 64'd1; req1_y = 64'd1; req1_sel = SEL_ADD;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;

    // ---- 1: reset then a single port-0 request ----
    repeat (3) next_cycle();
    #1;
    check("rst_req0_ready", {63'd0, req0_ready}, 64'd0);
    check("rst_req1_ready", {63'd0, req1_ready}, 64'd0);
    check("rst_rsp0_valid", {63'd0, rsp0_valid}, 64'd0);
    check("rst_rsp1_valid", {63'd0, rsp1_valid}, 64'd0);
    check("rst_rsp0_z", rsp0_z, 64'd0);

    next_cycle();
    rst = 1'b0; req1_valid = 1'b0;
    #1;
    check("t1_req0_ready", {63'd0, req0_ready}, 64'd1);
    check("t1_req1_ready", {63'd0, req1_ready}, 64'd0);
    next_cycle();
    req0_valid = 1'b0;
    #1;
    check("t1_rsp0_valid", {63'd0, rsp0_valid}, 64'd1);
    check("t1_rsp0_z", rsp0_z, 64'd12);
    check("t1_rsp1_valid", {63'd0, rsp1_valid}, 64'd0);

    // ---- 2: both requesting every cycle; rr_last is 0 so port 1 goes first ----
    next_cycle();
    req0_valid = 1'b1; req0_x = 64'd10;   req0_y = 64'd3;    req0_sel = SEL_SUB;
    req1_valid = 1'b1; req1_x = 64'hF0;   req1_y = 64'h0F;   req1_sel = SEL_XOR;
    #1;
    check("t2a_req1_ready", {63'd0, req1_ready}, 64'd1);
    check("t2a_req0_ready", {63'd0, req0_ready}, 64'd0);
    next_cycle(); #1;
    check("t2b_req0_ready", {63'd0, req0_ready}, 64'd1);
    check("t2b_rsp1_valid", {63'd0, rsp1_valid}, 64'd1);
    check("t2b_rsp1_z", rsp1_z, 64'hFF);
    check("t2b_rsp0_valid", {63'd0, rsp0_valid}, 64'd0);
    next_cycle(); #1;
    check("t2c_req1_ready", {63'd0, req1_ready}, 64'd1);
    check("t2c_rsp0_valid", {63'd0, rsp0_valid}, 64'd1);
    check("t2c_rsp0_z", rsp0_z, 64'd7);
    next_cycle(); #1;
    check("t2d_req0_ready", {63'd0, req0_ready}, 64'd1);
    check("t2d_rsp1_z", rsp1_z, 64'hFF);
    next_cycle();
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check("t2e_rsp0_valid", {63'd0, rsp0_valid}, 64'd1);
    check("t2e_rsp0_z", rsp0_z, 64'd7);
    next_cycle(); #1;
    check("t2f_rsp0_valid", {63'd0, rsp0_valid}, 64'd0);
    check("t2f_rsp1_valid", {63'd0, rsp1_valid}, 64'd0);

    // ---- 3: port-0 result stalls, port 1 must wait, then cross drain ----
    req0_valid = 1'b1; req0_x = 64'd100; req0_y = 64'd1; req0_sel = SEL_ADD;
    #1;
    check("t3_req0_ready", {63'd0, req0_ready}, 64'd1);
    next_cycle();
    req0_valid = 1'b0; req1_valid = 1'b1; rsp0_ready = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("t3_stall_req1_ready", {63'd0, req1_ready}, 64'd0);
      check("t3_stall_rsp0_valid", {63'd0, rsp0_valid}, 64'd1);
      check("t3_stall_rsp0_z", rsp0_z, 64'd101);
      next_cycle(); #1;
    end
    rsp0_ready = 1'b1;
    #1;
    check("t3_cross_req1_ready", {63'd0, req1_ready}, 64'd1);
    check("t3_cross_rsp0_valid", {63'd0, rsp0_valid}, 64'd1);
    next_cycle();
    req1_valid = 1'b0;
    #1;
    check("t3_rsp0_gone", {63'd0, rsp0_valid}, 64'd0);
    check("t3_rsp1_valid", {63'd0, rsp1_valid}, 64'd1);
    check("t3_rsp1_z", rsp1_z, 64'hFF);

    // ---- 4: back-to-back SLT then SLTU on port 1 ----
    next_cycle();
    req1_valid = 1'b1; req1_x = 64'hFFFF_FFFF_FFFF_FFFF; req1_y = 64'd0; req1_sel = SEL_SLT;
    #1;
    check("t4_slt_ready", {63'd0, req1_ready}, 64'd1);
    next_cycle();
    req1_sel = SEL_SLTU;
    #1;
    check("t4_sltu_ready", {63'd0, req1_ready}, 64'd1);
    check("t4_slt_valid", {63'd0, rsp1_valid}, 64'd1);
    check("t4_slt_z", rsp1_z, 64'd1);
    next_cycle();
    req1_x = 64'd2; req1_y = 64'd3; req1_sel = SEL_ADD;
    #1;
    check("t4_sltu_valid", {63'd0, rsp1_valid}, 64'd1);
    check("t4_sltu_z", rsp1_z, 64'd0);

    // ---- 5: reset while port 1 owns a held result ----
    check("t5_add_ready", {63'd0, req1_ready}, 64'd1);
    next_cycle();
    req1_valid = 1'b0; rsp1_ready = 1'b0;
    #1;
    check("t5_held_valid", {63'd1, rsp1_valid}, {63'd1, 1'b1});
    check("t5_held_z", rsp1_z, 64'd5);
    next_cycle();
    rst = 1'b1;
    req0_valid = 1'b1; req0_x = 64'd5;  req0_y = 64'd7; req0_sel = SEL_ADD;
    req1_valid = 1'b1; req1_x = 64'd10; req1_y = 64'd3; req1_sel = SEL_SUB;
    #1;
    check("t5_rst_req0_ready", {63'd0, req0_ready}, 64'd0);
    check("t5_rst_req1_ready", {63'd0, req1_ready}, 64'd0);
    next_cycle();
    rst = 1'b0; rsp1_ready = 1'b1;
    #1;
    check("t5_dropped_rsp1", {63'd0, rsp1_valid}, 64'd0);
    check("t5_dropped_z", rsp1_z, 64'd0);
    check("t5_first_req0", {63'd0, req0_ready}, 64'd1);
    check("t5_first_req1", {63'd0, req1_ready}, 64'd0);

    // ---- 6: port 0 withdraws while stalled; port 1 gets the grant ----
    next_cycle();
    rsp0_ready = 1'b0;
    #1;
    check("t6_rsp0_valid", {63'd0, rsp0_valid}, 64'd1);
    check("t6_rsp0_z", rsp0_z, 64'd12);
    check("t6_stall_req0", {63'd0, req0_ready}, 64'd0);
    check("t6_stall_req1", {63'd0, req1_ready}, 64'd0);
    next_cycle();
    req0_valid = 1'b0; rsp0_ready = 1'b1;
    #1;
    check("t6_req1_granted", {63'd0, req1_ready}, 64'd1);
    check("t6_req0_not", {63'd0, req0_ready}, 64'd0);
    next_cycle();
    req1_valid = 1'b0;
    #1;
    check("t6_rsp1_valid", {63'd0, rsp1_valid}, 64'd1);
    check("t6_rsp1_z", rsp1_z, 64'd7);
    check("t6_no_rsp0", {63'd0, rsp0_valid}, 64'd0);
    for (int i = 0; i < 2; i++) begin
      next_cycle(); #1;
      check("t6_idle_rsp0", {63'd0, rsp0_valid}, 64'd0);
    end

    // ---- 7: logic/shift ops streamed back-to-back on port 0 ----
    for (int i = 0; i <= 5; i++) begin
      if (i < 5) begin
        req0_valid = 1'b1; req0_x = tx[i]; req0_y = ty[i]; req0_sel = tsel[i];
      end else begin
        req0_valid = 1'b0;
      end
      #1;
      if (i < 5) check("t7_req0_ready", {63'd0, req0_ready}, 64'd1);
      if (i > 0) begin
        check("t7_rsp0_valid", {63'd0, rsp0_valid}, 64'd1);
        check("t7_rsp0_z", rsp0_z, tz[i-1]);
      end
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound so the bench always terminates
  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
